scan_load_ctrl: RTL
===================

Name: scan_load_ctrl

Overview:
- Sequencer that serially loads an L-word x B-bit configuration into the team's scan chain (chain of L*B dffs clocked by clk_scan, serial input d_in, serial output q_out).
- Accepts parallel words over a valid/ready handshake, serializes them onto d_in, generates clk_scan pulses from the system clock, and optionally captures the previous chain contents from q_out as parallel readback words.
- Sits between the register/host interface and the scan_part instance.

Parameters:
- L, 4, number of words in the chain (>=1)
- B, 8, bits per word (>=1)
- DIV, 1, system-clock cycles per scan-clock phase (>=1); one scan bit = 2*DIV cycles

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a full-chain load; ignored unless idle
- abort  in  1  terminate the current load immediately
- in_data  in  B  configuration word
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts in_data this cycle
- in_idx  out  $clog2(L) (min 1)  index of the word currently requested
- scan_clk  out  1  drives clk_scan of the chain
- scan_d  out  1  drives d_in of the chain
- scan_q  in  1  from q_out of the chain
- rd_data  out  B  readback word (old chain contents)
- rd_valid  out  1  single-cycle strobe, rd_data valid; no backpressure
- busy  out  1  load in progress
- done  out  1  single-cycle pulse on successful completion

Behaviour:
- Reset: state IDLE; in_ready, scan_clk, scan_d, rd_valid, busy, done = 0; rd_data = 0; in_idx = L-1; all counters 0.
- Shift order: words L-1 down to 0, within a word bit B-1 down to 0. After L*B pulses, chain position q[w][b] holds in_data bit b of word w.
- States:
  - IDLE: busy=0. start=1 -> FETCH with in_idx=L-1.
  - FETCH: busy=1, in_ready=1. in_valid&in_ready -> latch word into shift reg, bit counter=B-1 -> LO. Waits indefinitely otherwise.
  - LO: scan_clk=0, scan_d=current bit, held DIV cycles. On the final LO cycle sample scan_q into readback reg (pre-edge value) -> HI.
  - HI: scan_clk=1 for DIV cycles (rising edge on LO->HI transition shifts chain). Exit: bit counter>0 -> decrement -> LO; else word done: in_idx>0 -> decrement -> FETCH; in_idx==0 -> DONE.
  - DONE: one cycle, done=1, busy=1; then IDLE with scan_clk=0.
- scan_clk and scan_d are registered outputs (glitch-free); scan_d changes only while scan_clk=0 (LO entry), never coincident with a rising edge.
- Readback: after the last HI of each word, rd_data = B sampled bits (first sample is MSB), rd_valid=1 for one cycle. Readback word order L-1 first, i.e. same order/index as in_idx.
- Latency: from accepted word to its last rising edge = 2*DIV*B cycles; full load = L*(2*DIV*B) + L fetch cycles min + 1 DONE cycle.
- start while busy: ignored. start and abort same cycle in IDLE: abort wins (stay IDLE).
- abort in any non-IDLE state: next cycle IDLE, scan_clk=0, in_ready=0, no done, no rd_valid for the partial word; chain contents undefined (partial shift).
- in_valid while not in_ready: ignored, no state change.
- Asynchronous reset mid-load: immediate return to reset values; scan_clk forced 0.

Optional Feature:
- SCAN_LOAD_READBACK_EN: defined -> scan_q sampled, rd_data/rd_valid as above. Undefined -> no readback register, rd_data tied 0, rd_valid tied 0, scan_q unused; shift timing identical.

Test Plan:
- L=2,B=4,DIV=1, chain reset-state 0: start, supply word1=0xA then word0=0x3 -> scan_d sequence on rising scan_clk edges 1,0,1,0,0,0,1,1; 8 scan_clk pulses; done one cycle after last HI; chain q[1]=0xA, q[0]=0x3.
- Repeat load with word1=0x5, word0=0xC (readback enabled) -> rd_valid twice, rd_data 0xA then 0x3; chain then q[1]=0x5, q[0]=0xC.
- DIV=3: scan_clk low 3 cycles / high 3 cycles per bit; scan_d stable across each rising edge; 4-bit word takes 24 cycles.
- Delay in_valid 5 cycles during FETCH of word0 -> scan_clk held 0, in_ready held 1, no extra pulses; load completes correctly.
- abort in the middle of word1 shifting -> next cycle IDLE, busy=0, scan_clk=0, no done, no rd_valid; subsequent start performs a full correct load.
- Assert rst_n low during HI -> scan_clk and all outputs 0 immediately; start after release performs a normal load; start while busy ignored (pulse count stays L*B).

Source files
------------

// File: rtl/scan_load_ctrl_if.sv
// scan_load_ctrl_if: word-request handshake between the host and the scan loader.
interface scan_load_ctrl_if #(
   parameter int L = 4,
   parameter int B = 8
);
   localparam int IW = (L > 1) ? $clog2(L) : 1;
   logic [B-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in_idx;
   modport master (output in_data, in_valid, input in_ready, in_idx);
   modport slave  (input in_data, in_valid, output in_ready, in_idx);
endinterface

// File: rtl/scan_load_ctrl.sv
// scan_load_ctrl: serially loads L words of B bits into a scan chain, MSB of word L-1 first.
// Define SCAN_LOAD_READBACK_EN to capture the previous chain contents as readback words.
module scan_load_ctrl #(
   parameter int L   = 4,
   parameter int B   = 8,
   parameter int DIV = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_start,
   input  logic            i_abort,
   scan_load_ctrl_if.slave bus,
   output logic            o_scan_clk,
   output logic            o_scan_d,
   input  logic            i_scan_q,
   output logic [B-1:0]    o_rd_data,
   output logic            o_rd_valid,
   output logic            o_busy,
   output logic            o_done
);
   localparam int IW = (L > 1) ? $clog2(L) : 1;
   localparam int BW = (B > 1) ? $clog2(B) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, LO, HI, DONE} state_t;

   state_t        r_state;
   logic [B-1:0]  r_sh;
   logic [BW-1:0] r_bit;
   logic [DW-1:0] r_div;
   logic [IW-1:0] r_idx;
   logic          r_ready;
   logic          w_div_last;
   logic [B-1:0]  w_sh_next;

   assign w_div_last   = r_div == DW'(DIV - 1);
   assign w_sh_next    = B'({r_sh, 1'b0});
   assign o_scan_d     = r_sh[B-1];
   assign bus.in_ready = r_ready;
   assign bus.in_idx   = r_idx;

   // Shift register MSB is the scan data output, so scan_d only moves when r_sh is reloaded at LO entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_sh       <= '0;
         r_bit      <= '0;
         r_div      <= '0;
         r_idx      <= IW'(L - 1);
         r_ready    <= 1'b0;
         o_scan_clk <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else if (i_abort) begin
         r_state    <= IDLE;
         r_sh       <= '0;
         r_div      <= '0;
         r_ready    <= 1'b0;
         o_scan_clk <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            IDLE: if (i_start) begin
               r_state <= FETCH;
               r_ready <= 1'b1;
               o_busy  <= 1'b1;
               r_idx   <= IW'(L - 1);
            end
            FETCH: if (bus.in_valid && r_ready) begin
               r_state <= LO;
               r_ready <= 1'b0;
               r_sh    <= bus.in_data;
               r_bit   <= BW'(B - 1);
               r_div   <= '0;
            end
            LO: begin
               r_div <= w_div_last ? '0 : r_div + 1'b1;
               if (w_div_last) begin
                  r_state    <= HI;
                  o_scan_clk <= 1'b1;
               end
            end
            HI: begin
               r_div <= w_div_last ? '0 : r_div + 1'b1;
               if (w_div_last) begin
                  o_scan_clk <= 1'b0;
                  if (r_bit != '0) begin
                     r_state <= LO;
                     r_bit   <= r_bit - 1'b1;
                     r_sh    <= w_sh_next;
                  end else if (r_idx != '0) begin
                     r_state <= FETCH;
                     r_idx   <= r_idx - 1'b1;
                     r_ready <= 1'b1;
                  end else begin
                     r_state <= DONE;
                     o_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               o_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef SCAN_LOAD_READBACK_EN
   logic         w_sample;
   logic         w_word_end;
   logic [B-1:0] r_rb;
   logic [B-1:0] r_rd_data;
   logic         r_rd_valid;

   // scan_q is sampled on the last low cycle, i.e. before the rising edge shifts the chain.
   assign w_sample   = (r_state == LO) && w_div_last && !i_abort;
   assign w_word_end = (r_state == HI) && w_div_last && (r_bit == '0) && !i_abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rb       <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_word_end;
         if (w_sample) r_rb <= B'({r_rb, i_scan_q});
         if (w_word_end) r_rd_data <= r_rb;
      end
   end

   assign o_rd_data  = r_rd_data;
   assign o_rd_valid = r_rd_valid;
`else
   logic w_unused_scan_q;
   assign w_unused_scan_q = i_scan_q;
   assign o_rd_data       = '0;
   assign o_rd_valid      = 1'b0;
`endif
endmodule
